key_bank: RTL and testbench

Multi-slot key store that replaces the single fixed-size key register bank in the crypto datapath. Holds up to SLOTS independent keys of up to WORDS words each, with per-slot length and valid flags. Keys are loaded word-by-word over a valid/ready stream and can be zeroized on command. A cipher engine reads any slot in parallel, and loads or zeroizes to a slot it is using are stalled.

---
 rtl/key_bank_pkg.sv | 17 +
 rtl/key_bank_if.sv | 43 ++++
 rtl/key_slot.sv | 64 ++++++
 rtl/key_bank.sv | 148 ++++++++++++++
 tb/tb_key_bank.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/key_bank_pkg.sv
// Shared constants and types for the multi-slot key store.
package key_bank_pkg;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_ZERO = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    // Index width that stays at least one bit for single-entry arrays.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_bank_if.sv
// Command, key-word stream and engine read port of the key store.
interface key_bank_if #(
    parameter int unsigned SLOTS     = 4,
    parameter int unsigned WORDS     = 8,
    parameter int unsigned WORD_SIZE = 32
) ();
    localparam int unsigned SW = key_bank_pkg::idx_w(SLOTS);
    localparam int unsigned LW = $clog2(WORDS + 1);
    localparam int unsigned KW = WORDS * WORD_SIZE;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_op;
    logic [SW-1:0]        cmd_slot;
    logic [LW-1:0]        cmd_len;
    logic                 cmd_err;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [WORD_SIZE-1:0] wr_data;
    logic [SW-1:0]        rd_slot;
    logic                 rd_hold;
    logic [KW-1:0]        rd_key;
    logic [LW-1:0]        rd_len;
    logic                 rd_keyvalid;
    logic                 busy;

    modport master (
        output cmd_valid, cmd_op, cmd_slot, cmd_len,
        output wr_valid, wr_data,
        output rd_slot, rd_hold,
        input  cmd_ready, cmd_err, wr_ready,
        input  rd_key, rd_len, rd_keyvalid, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_slot, cmd_len,
        input  wr_valid, wr_data,
        input  rd_slot, rd_hold,
        output cmd_ready, cmd_err, wr_ready,
        output rd_key, rd_len, rd_keyvalid, busy
    );

endinterface

// File: rtl/key_slot.sv
// One key slot: WORDS data words, a length and a completion flag.
module key_slot
    import key_bank_pkg::*;
#(
    parameter int unsigned WORDS     = 8,
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       set_len,
    input  logic [$clog2(WORDS+1)-1:0] len_in,
    input  logic                       wr_en,
    input  logic [idx_w(WORDS)-1:0]    wr_idx,
    input  logic [WORD_SIZE-1:0]       wr_data,
    input  logic                       set_valid,
    output logic [WORDS*WORD_SIZE-1:0] words_o,
    output logic [$clog2(WORDS+1)-1:0] len_o,
    output logic                       valid_o
);
    localparam int unsigned LW = $clog2(WORDS + 1);

    logic [WORDS-1:0][WORD_SIZE-1:0] words_q, words_d;
    logic [LW-1:0]                   len_q, len_d;
    logic                            valid_q, valid_d;

    // Clear first so a LOAD can wipe the slot and set its new length together.
    always_comb begin
        words_d = words_q;
        len_d   = len_q;
        valid_d = valid_q;
        if (clear) begin
            words_d = '0;
            len_d   = '0;
            valid_d = 1'b0;
        end
        if (set_len) begin
            len_d = len_in;
        end
        if (wr_en) begin
            words_d[wr_idx] = wr_data;
        end
        if (set_valid) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            words_q <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            words_q <= words_d;
            len_q   <= len_d;
            valid_q <= valid_d;
        end
    end

    assign words_o = words_q;
    assign len_o   = len_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/key_bank.sv
// Multi-slot key store: stream loader, zeroize, hold interlock and registered read mux.
module key_bank
    import key_bank_pkg::*;
#(
    parameter int unsigned SLOTS     = 4,
    parameter int unsigned WORDS     = 8,
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic       clk,
    input  logic       rst,
    key_bank_if.slave  bus
);
    localparam int unsigned SW = idx_w(SLOTS);
    localparam int unsigned LW = $clog2(WORDS + 1);
    localparam int unsigned IW = idx_w(WORDS);
    localparam int unsigned KW = WORDS * WORD_SIZE;

    state_e          state_q, state_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic            cmd_err_q, cmd_err_d;
    logic [KW-1:0]   rd_key_q, rd_key_d;
    logic [LW-1:0]   rd_len_q, rd_len_d;
    logic            rd_keyvalid_q, rd_keyvalid_d;

    logic [SLOTS-1:0] slot_clear;
    logic [SLOTS-1:0] slot_set_len;
    logic [SLOTS-1:0] slot_wr_en;
    logic [SLOTS-1:0] slot_set_valid;
    logic [KW-1:0]    slot_words [SLOTS];
    logic [LW-1:0]    slot_len   [SLOTS];
    logic [SLOTS-1:0] slot_valid;

    logic            cmd_ready_c;
    logic            cmd_fire_c;
    logic            len_ok_c;
    logic [LW-1:0]   cur_len_c;
    logic [IW-1:0]   wr_idx_c;

    assign wr_idx_c  = IW'(cnt_q);
    assign cur_len_c = slot_len[slot_q];

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        key_slot #(
            .WORDS     (WORDS),
            .WORD_SIZE (WORD_SIZE)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .clear     (slot_clear[g]),
            .set_len   (slot_set_len[g]),
            .len_in    (bus.cmd_len),
            .wr_en     (slot_wr_en[g]),
            .wr_idx    (wr_idx_c),
            .wr_data   (bus.wr_data),
            .set_valid (slot_set_valid[g]),
            .words_o   (slot_words[g]),
            .len_o     (slot_len[g]),
            .valid_o   (slot_valid[g])
        );
    end

    // Command acceptance, load sequencing and per-slot strobes.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        slot_d         = slot_q;
        cmd_err_d      = 1'b0;
        slot_clear     = '0;
        slot_set_len   = '0;
        slot_wr_en     = '0;
        slot_set_valid = '0;

        // Commands to the slot the engine is holding wait; others pass.
        cmd_ready_c = (state_q == ST_IDLE) &&
                      !(bus.rd_hold && (bus.cmd_slot == bus.rd_slot));
        cmd_fire_c  = bus.cmd_valid && cmd_ready_c;
        len_ok_c    = (bus.cmd_len != '0) && (bus.cmd_len <= LW'(WORDS));

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire_c) begin
                    if (bus.cmd_op == OP_ZERO) begin
                        slot_clear[bus.cmd_slot] = 1'b1;
                    end else if (!len_ok_c) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        slot_clear[bus.cmd_slot]   = 1'b1;
                        slot_set_len[bus.cmd_slot] = 1'b1;
                        slot_d  = bus.cmd_slot;
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.wr_valid) begin
                    slot_wr_en[slot_q] = 1'b1;
                    cnt_d = cnt_q + LW'(1);
                    if (cnt_q == (cur_len_c - LW'(1))) begin
                        slot_set_valid[slot_q] = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Engine read mux, sampled one cycle behind the slot registers.
    always_comb begin
        rd_key_d      = slot_words[bus.rd_slot];
        rd_len_d      = slot_len[bus.rd_slot];
        rd_keyvalid_d = slot_valid[bus.rd_slot];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            slot_q        <= '0;
            cmd_err_q     <= 1'b0;
            rd_key_q      <= '0;
            rd_len_q      <= '0;
            rd_keyvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            cmd_err_q     <= cmd_err_d;
            rd_key_q      <= rd_key_d;
            rd_len_q      <= rd_len_d;
            rd_keyvalid_q <= rd_keyvalid_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_c;
    assign bus.cmd_err     = cmd_err_q;
    assign bus.wr_ready    = (state_q == ST_LOAD);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.rd_key      = rd_key_q;
    assign bus.rd_len      = rd_len_q;
    assign bus.rd_keyvalid = rd_keyvalid_q;

endmodule

// File: tb/tb_key_bank.sv
// Directed bench for key_bank: loads, overwrite, hold interlock, illegal lengths, gaps, reset.
module tb_key_bank;
    import key_bank_pkg::*;

    localparam int unsigned SLOTS     = 4;
    localparam int unsigned WORDS     = 8;
    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned KW        = WORDS * WORD_SIZE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_bank_if #(.SLOTS(SLOTS), .WORDS(WORDS), .WORD_SIZE(WORD_SIZE)) bus ();

    key_bank #(.SLOTS(SLOTS), .WORDS(WORDS), .WORD_SIZE(WORD_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] wbuf [8];

    task automatic check(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [KW-1:0] exp_key(input int n);
        logic [KW-1:0] k = '0;
        for (int i = 0; i < n; i++) k[i*32 +: 32] = wbuf[i];
        return k;
    endfunction

    task automatic send_cmd(input logic op, input logic [1:0] slot, input logic [3:0] len);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_slot  = slot;
        bus.cmd_len   = len;
        #1;
        while (!bus.cmd_ready && n < 20) begin
            step();
            n++;
        end
        if (!bus.cmd_ready) begin
            check("cmd_timeout", KW'(bus.cmd_ready), KW'(1));
        end else begin
            step();
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_words(input int first, input int n, input bit gaps);
        for (int i = first; i < first + n; i++) begin
            if (gaps) begin
                int g = 0;
                while ($urandom_range(0, 1) == 1 && g < 3) begin
                    bus.wr_valid = 1'b0;
                    bus.wr_data  = $urandom;
                    step();
                    g++;
                end
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = wbuf[i];
            #1;
            check("wr_ready", KW'(bus.wr_ready), KW'(1));
            step();
        end
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_slot  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_slot   = '0;
        bus.rd_hold   = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_cmd_ready", KW'(bus.cmd_ready), KW'(1));
        check("rst_wr_ready", KW'(bus.wr_ready), KW'(0));
        check("rst_cmd_err", KW'(bus.cmd_err), KW'(0));
        check("rst_busy", KW'(bus.busy), KW'(0));
        check("rst_rd_key", bus.rd_key, '0);
        check("rst_rd_len", KW'(bus.rd_len), KW'(0));
        check("rst_keyvalid", KW'(bus.rd_keyvalid), KW'(0));

        // Slot 1, four words
        for (int i = 0; i < 8; i++) wbuf[i] = (i < 4) ? 32'(32'h1111_1111 * (i + 1)) : 32'h0;
        bus.rd_slot = 2'd1;
        send_cmd(OP_LOAD, 2'd1, 4'd4);
        check("t1_busy_hi", KW'(bus.busy), KW'(1));
        check("t1_cmd_ready_lo", KW'(bus.cmd_ready), KW'(0));
        send_words(0, 2, 1'b0);
        check("t1_kv_partial", KW'(bus.rd_keyvalid), KW'(0));
        send_words(2, 2, 1'b0);
        check("t1_busy_lo", KW'(bus.busy), KW'(0));
        step();
        check("t1_keyvalid", KW'(bus.rd_keyvalid), KW'(1));
        check("t1_len", KW'(bus.rd_len), KW'(4));
        check("t1_key", bus.rd_key, 256'h4444_4444_3333_3333_2222_2222_1111_1111);

        // Slot 2, eight words then overwritten with four
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hA000_0000 + 32'(i);
        bus.rd_slot = 2'd2;
        send_cmd(OP_LOAD, 2'd2, 4'd8);
        send_words(0, 8, 1'b0);
        step();
        check("t2_len8", KW'(bus.rd_len), KW'(8));
        check("t2_key8", bus.rd_key, exp_key(8));
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hB000_0000 + 32'(i);
        send_cmd(OP_LOAD, 2'd2, 4'd4);
        send_words(0, 4, 1'b0);
        step();
        check("t2_len4", KW'(bus.rd_len), KW'(4));
        check("t2_key4", bus.rd_key, exp_key(4));
        check("t2_upper_zero", KW'(bus.rd_key[255:128]), '0);

        // Hold interlock on slot 0 while slot 3 loads
        wbuf[0] = 32'hC000_0000;
        wbuf[1] = 32'hC000_0001;
        send_cmd(OP_LOAD, 2'd0, 4'd2);
        send_words(0, 2, 1'b0);
        bus.rd_slot   = 2'd0;
        bus.rd_hold   = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_ZERO;
        bus.cmd_slot  = 2'd0;
        bus.cmd_len   = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_hold_block", KW'(bus.cmd_ready), KW'(0));
            step();
        end
        check("t3_kv_held", KW'(bus.rd_keyvalid), KW'(1));
        bus.cmd_op   = OP_LOAD;
        bus.cmd_slot = 2'd3;
        bus.cmd_len  = 4'd1;
        #1;
        check("t3_other_ready", KW'(bus.cmd_ready), KW'(1));
        wbuf[0] = 32'hD00D_0001;
        send_cmd(OP_LOAD, 2'd3, 4'd1);
        send_words(0, 1, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_ZERO;
        bus.cmd_slot  = 2'd0;
        #1;
        check("t3_still_block", KW'(bus.cmd_ready), KW'(0));
        step();
        step();
        bus.rd_hold = 1'b0;
        send_cmd(OP_ZERO, 2'd0, 4'd0);
        step();
        check("t3_zero_kv", KW'(bus.rd_keyvalid), KW'(0));
        check("t3_zero_len", KW'(bus.rd_len), KW'(0));
        check("t3_zero_key", bus.rd_key, '0);
        bus.rd_slot = 2'd3;
        step();
        check("t3_s3_kv", KW'(bus.rd_keyvalid), KW'(1));
        check("t3_s3_len", KW'(bus.rd_len), KW'(1));
        check("t3_s3_key", bus.rd_key, KW'(32'hD00D_0001));

        // Illegal lengths 0 and 9
        bus.rd_slot = 2'd1;
        send_cmd(OP_LOAD, 2'd1, 4'd0);
        check("t4_err0_hi", KW'(bus.cmd_err), KW'(1));
        check("t4_err0_busy", KW'(bus.busy), KW'(0));
        step();
        check("t4_err0_lo", KW'(bus.cmd_err), KW'(0));
        send_cmd(OP_LOAD, 2'd1, 4'd9);
        check("t4_err9_hi", KW'(bus.cmd_err), KW'(1));
        check("t4_err9_busy", KW'(bus.busy), KW'(0));
        step();
        check("t4_err9_lo", KW'(bus.cmd_err), KW'(0));
        check("t4_s1_len", KW'(bus.rd_len), KW'(4));
        check("t4_s1_kv", KW'(bus.rd_keyvalid), KW'(1));
        check("t4_s1_key", bus.rd_key, 256'h4444_4444_3333_3333_2222_2222_1111_1111);

        // Idle writes ignored, then eight words with random gaps
        bus.rd_slot  = 2'd0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hDEAD_BEEF;
        #1;
        check("t5_idle_wr_ready", KW'(bus.wr_ready), KW'(0));
        step();
        step();
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h0F0F_0000 | 32'(i * 17);
        send_cmd(OP_LOAD, 2'd0, 4'd8);
        send_words(0, 8, 1'b1);
        check("t5_busy_lo", KW'(bus.busy), KW'(0));
        step();
        check("t5_key", bus.rd_key, exp_key(8));
        check("t5_len", KW'(bus.rd_len), KW'(8));
        check("t5_kv", KW'(bus.rd_keyvalid), KW'(1));
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hFFFF_FFFF;
        step();
        step();
        step();
        bus.wr_valid = 1'b0;
        step();
        check("t5_key_unchanged", bus.rd_key, exp_key(8));

        // Reset in the middle of a six-word load
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h6000_0000 + 32'(i);
        send_cmd(OP_LOAD, 2'd1, 4'd6);
        send_words(0, 2, 1'b0);
        check("t6_busy_mid", KW'(bus.busy), KW'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_busy_lo", KW'(bus.busy), KW'(0));
        check("t6_wr_ready_lo", KW'(bus.wr_ready), KW'(0));
        for (int s = 0; s < 4; s++) begin
            bus.rd_slot = 2'(s);
            step();
            check("t6_len_zero", KW'(bus.rd_len), KW'(0));
            check("t6_kv_zero", KW'(bus.rd_keyvalid), KW'(0));
            check("t6_key_zero", bus.rd_key, '0);
        end
        send_cmd(OP_LOAD, 2'd1, 4'd3);
        send_words(0, 3, 1'b0);
        bus.rd_slot = 2'd1;
        step();
        check("t6_reload_len", KW'(bus.rd_len), KW'(3));
        check("t6_reload_kv", KW'(bus.rd_keyvalid), KW'(1));
        check("t6_reload_key", bus.rd_key, exp_key(3));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
